// File: rtl/fault_pkg.sv
// fault_pkg: shared state encoding and default recovery length for the CAN fault-confinement block
package fault_pkg;
  typedef enum logic [1:0] {ERR_ACTIVE, ERR_PASSIVE, BUS_OFF, RECOVER} state_t;
  localparam int DEF_RECOVERY_COUNT = 128;
endpackage

// File: rtl/busoff_recovery_counter.sv
// busoff_recovery_counter: counts elevrecb high phases while bus-off
// Ports: clock/reset (sync, active-low); enable = node is bus-off; clear = entering bus-off;
//        elevrecb = 11-recessive-bit level from MAC; done = this count completes recovery;
//        cnt = current recovery count.
module busoff_recovery_counter import fault_pkg::*; #(
  parameter int RECOVERY_COUNT = DEF_RECOVERY_COUNT,
  parameter int RCNT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              elevrecb,
  output logic              done,
  output logic [RCNT_W-1:0] cnt
);
  logic seen;
  logic rise;
  // seen tracks the previous elevrecb level, so a level already high when bus-off is entered is not counted
  assign rise = enable & elevrecb & ~seen;
  assign done = rise & (cnt == RCNT_W'(RECOVERY_COUNT - 1));
  always_ff @(posedge clock)
    if (!reset) begin
      seen <= 1'b0;
      cnt  <= '0;
    end else begin
      seen <= elevrecb;
      cnt  <= (clear | done) ? '0 : rise ? cnt + 1'b1 : cnt;
    end
endmodule

// File: rtl/fault_confinement_fsm.sv
// fault_confinement_fsm: CAN error-active / error-passive / bus-off state machine with bus-off recovery
// Ports: clock/reset (sync, active-low); rec_ge96/rec_ge128/tec_ge96/tec_ge128/tec_ge256 counter flags;
//        elevrecb from MAC; erroractive/errorpassive/busoff node state; warnsig warning level;
//        resetcount active-low counter clear; recovery_cnt status; state_irq (FAULTFSM_STATE_IRQ_EN only).
module fault_confinement_fsm import fault_pkg::*; #(
  parameter int RECOVERY_COUNT = DEF_RECOVERY_COUNT,
  parameter int RCNT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rec_ge96,
  input  logic              rec_ge128,
  input  logic              tec_ge96,
  input  logic              tec_ge128,
  input  logic              tec_ge256,
  input  logic              elevrecb,
  output logic              erroractive,
  output logic              errorpassive,
  output logic              busoff,
  output logic              warnsig,
  output logic              resetcount,
  output logic [RCNT_W-1:0] recovery_cnt
`ifdef FAULTFSM_STATE_IRQ_EN
  ,
  output logic              state_irq
`endif
);
  state_t state, nxt;
  logic done;
  busoff_recovery_counter #(.RECOVERY_COUNT(RECOVERY_COUNT), .RCNT_W(RCNT_W)) u_rcnt (
    .clock   (clock),
    .reset   (reset),
    .enable  (state == BUS_OFF),
    .clear   (nxt == BUS_OFF && state != BUS_OFF),
    .elevrecb(elevrecb),
    .done    (done),
    .cnt     (recovery_cnt)
  );
  // tec_ge256 is checked first so bus-off wins over any inconsistent flag mix
  always_comb begin
    nxt = ERR_ACTIVE;
    case (state)
      ERR_ACTIVE:  nxt = tec_ge256 ? BUS_OFF : (rec_ge128 | tec_ge128) ? ERR_PASSIVE : ERR_ACTIVE;
      ERR_PASSIVE: nxt = tec_ge256 ? BUS_OFF : (rec_ge128 | tec_ge128) ? ERR_PASSIVE : ERR_ACTIVE;
      BUS_OFF:     nxt = done ? RECOVER : BUS_OFF;
      default:     nxt = ERR_ACTIVE;
    endcase
  end
  // outputs decode the next state so they change on the same edge as the state register
  always_ff @(posedge clock)
    if (!reset) begin
      state        <= ERR_ACTIVE;
      erroractive  <= 1'b1;
      errorpassive <= 1'b0;
      busoff       <= 1'b0;
      warnsig      <= 1'b0;
      resetcount   <= 1'b1;
    end else begin
      state        <= nxt;
      erroractive  <= nxt == ERR_ACTIVE || nxt == RECOVER;
      errorpassive <= nxt == ERR_PASSIVE;
      busoff       <= nxt == BUS_OFF;
      warnsig      <= nxt == BUS_OFF ? 1'b1 : nxt == RECOVER ? 1'b0 : rec_ge96 | tec_ge96;
      resetcount   <= nxt != RECOVER;
    end
`ifdef FAULTFSM_STATE_IRQ_EN
  always_ff @(posedge clock)
    if (!reset) state_irq <= 1'b0;
    else state_irq <= nxt != state;
`endif
endmodule

// File: tb/tb_fault_confinement_fsm.sv
// tb_fault_confinement_fsm: directed + randomized check of fault_confinement_fsm against a behavioural model
module tb_fault_confinement_fsm;
  localparam int RC = 128;
  localparam int A = 0, P = 1, B = 2, R = 3;
  logic clock = 0, reset = 0;
  logic rec_ge96 = 0, rec_ge128 = 0, tec_ge96 = 0, tec_ge128 = 0, tec_ge256 = 0, elevrecb = 0;
  logic erroractive, errorpassive, busoff, warnsig, resetcount;
  logic [7:0] recovery_cnt;
  int n_chk = 0, n_fail = 0;
  int m_mode = A, m_cnt = 0, m_warn = 0, m_irq = 0;
  bit m_prev = 0;
`ifdef FAULTFSM_STATE_IRQ_EN
  logic state_irq;
`endif
  fault_confinement_fsm dut (
    .clock(clock), .reset(reset),
    .rec_ge96(rec_ge96), .rec_ge128(rec_ge128), .tec_ge96(tec_ge96), .tec_ge128(tec_ge128),
    .tec_ge256(tec_ge256), .elevrecb(elevrecb),
    .erroractive(erroractive), .errorpassive(errorpassive), .busoff(busoff),
    .warnsig(warnsig), .resetcount(resetcount), .recovery_cnt(recovery_cnt)
`ifdef FAULTFSM_STATE_IRQ_EN
    , .state_irq(state_irq)
`endif
  );
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: node mode from the confinement rules, recovery counted as high phases of elevrecb
  task automatic model_edge();
    int old;
    old = m_mode;
    if (!reset) begin
      m_mode = A; m_cnt = 0; m_prev = 0; m_warn = 0; m_irq = 0;
    end else begin
      if (old == A || old == P) begin
        if (tec_ge256) begin m_mode = B; m_cnt = 0; end
        else m_mode = (rec_ge128 || tec_ge128) ? P : A;
      end else if (old == B) begin
        if (elevrecb && !m_prev) begin
          if (m_cnt + 1 == RC) begin m_mode = R; m_cnt = 0; end
          else m_cnt++;
        end
      end else m_mode = A;
      m_prev = elevrecb;
      m_warn = (m_mode == B) ? 1 : (m_mode == R) ? 0 : int'(rec_ge96 || tec_ge96);
      m_irq = int'(m_mode != old);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("erroractive", erroractive, m_mode == A || m_mode == R);
    chk("errorpassive", errorpassive, m_mode == P);
    chk("busoff", busoff, m_mode == B);
    chk("warnsig", warnsig, m_warn);
    chk("resetcount", resetcount, m_mode != R);
    chk("recovery_cnt", recovery_cnt, m_cnt);
`ifdef FAULTFSM_STATE_IRQ_EN
    chk("state_irq", state_irq, m_irq);
`endif
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic pulses(input int k);
    for (int i = 0; i < k; i++) begin
      elevrecb = 1; steps(3);
      elevrecb = 0; steps(2);
    end
  endtask

  task automatic clear_flags();
    rec_ge96 = 0; rec_ge128 = 0; tec_ge96 = 0; tec_ge128 = 0; tec_ge256 = 0;
  endtask

  initial begin
    steps(3);
    reset = 1;
    step();
    chk("reset_ea", erroractive, 1);
    chk("reset_rc", resetcount, 1);
    rec_ge96 = 1; step();
    chk("warn_rise", warnsig, 1);
    rec_ge128 = 1; step();
    chk("passive", errorpassive, 1);
    clear_flags(); step();
    chk("back_active", erroractive, 1);
    tec_ge256 = 1; rec_ge128 = 1; step();
    chk("busoff_prio", busoff, 1);
    clear_flags(); steps(2);
    pulses(127);
    chk("cnt127", recovery_cnt, 127);
    chk("still_busoff", busoff, 1);
    elevrecb = 1; step();
    chk("recover_pulse", resetcount, 0);
    step();
    chk("recover_done_ea", erroractive, 1);
    chk("recover_done_rc", resetcount, 1);
    chk("recover_done_cnt", recovery_cnt, 0);
    elevrecb = 0; steps(2);
    elevrecb = 1; tec_ge256 = 1; step();
    tec_ge256 = 0; steps(50);
    chk("entry_high_nocount", recovery_cnt, 0);
    elevrecb = 0; step();
    elevrecb = 1; steps(50);
    chk("long_high_one", recovery_cnt, 1);
    elevrecb = 0; step();
    pulses(59);
    chk("cnt60", recovery_cnt, 60);
    reset = 0; steps(2);
    reset = 1; step();
    chk("reset_mid_ea", erroractive, 1);
    chk("reset_mid_cnt", recovery_cnt, 0);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      if (m_mode == B) elevrecb = 1'($urandom_range(0, 1));
      else elevrecb = ($urandom_range(0, 3) == 0);
      rec_ge96 = 1'($urandom_range(0, 1));
      rec_ge128 = 1'($urandom_range(0, 1));
      tec_ge96 = 1'($urandom_range(0, 1));
      tec_ge128 = ($urandom_range(0, 3) == 0);
      tec_ge256 = ($urandom_range(0, 59) == 0);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
